nco_fft_framer: RTL
===================

# nco_fft_framer

Downstream consumer of the NCO core: takes the free-running `fsin_o`/`fcos_o`/`out_valid` sample stream and packs it into fixed-length complex frames on an Avalon-ST source for the FFT core. Cosine maps to the real part and sine to the imaginary part. A small FIFO absorbs FFT back-pressure. Frames are gated by a run-enable and always end on a frame boundary. Overflow drops are flagged per frame and held in a sticky status bit.

## Interface
Parameters:
- `MPR`, 14, sample width; must match the NCO magnitude precision.
- `FFT_LEN`, 1024, samples per frame; power of two, 4..65536.
- `LOG2_LEN`, 10, log2(`FFT_LEN`).
- `FIFO_DEPTH`, 16, FIFO entries; power of two, at least 4.
- `LOG2_DEPTH`, 4, log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run_en`  in  1  level; enables framing.
- `in_valid`  in  1  NCO `out_valid`.
- `in_sin`  in  MPR  NCO `fsin_o`, two's complement.
- `in_cos`  in  MPR  NCO `fcos_o`, two's complement.
- `src_valid`  out  1  Avalon-ST valid.
- `src_ready`  in  1  Avalon-ST ready; ready latency 0.
- `src_sop`  out  1  first sample of a frame.
- `src_eop`  out  1  last sample of a frame.
- `src_real`  out  MPR  carries `in_cos`.
- `src_imag`  out  MPR  carries `in_sin`.
- `src_error`  out  1  asserted on the eop beat of a frame that lost one or more samples.
- `ovf_sticky`  out  1  set on any dropped sample.
- `ovf_clr`  in  1  clears `ovf_sticky` (synchronous pulse).
- `busy`  out  1  FSM not in IDLE.
- `frame_cnt`  out  16  completed frames written; see Configuration.

## Operation
- **FSM states:** IDLE, RUN, FINISH.
  - IDLE → RUN when `run_en`=1. `run_en` is sampled every cycle; `in_valid` is ignored in IDLE.
  - RUN → FINISH when `run_en`=0 and the sample count is not 0.
  - RUN → IDLE when `run_en`=0 and the sample count is 0.
  - FINISH → IDLE after the eop sample is accepted. FINISH ignores `run_en`.
- **Sample count:** `LOG2_LEN` bits, 0..`FFT_LEN`-1.
  - It advances on every `in_valid` in RUN or FINISH, whether the sample is written or dropped.
  - Because dropped samples still advance the count, frames stay time-aligned to the NCO.
  - It wraps from `FFT_LEN`-1 to 0.
- **Sample tagging:** sop is tagged when the count is 0; eop is tagged when the count is `FFT_LEN`-1.
- **FIFO word:** {err, eop, sop, cos, sin}, `2*MPR+3` bits wide.
  - The word is written when `in_valid` is high, the FSM is in RUN or FINISH, and the FIFO is not full.
- **Overflow:** if `in_valid` arrives while the FIFO is full, the sample is dropped.
  - `ovf_sticky` is set, and an internal `frame_err` flag is set.
  - `frame_err` is ORed into the err bit of the eop word and cleared once the eop sample has been counted, whether it was written or dropped.
  - If the eop sample itself is dropped, the frame has no eop beat. The FFT sees a missing eop; software detects this through `ovf_sticky`.
- **Source interface:** driven from the FIFO head.
  - `src_valid` = FIFO not empty.
  - A read occurs when `src_valid` and `src_ready` are both high.
  - Simultaneous write and read while full: the read frees a slot, but the write is still dropped, because fullness is evaluated before the read.
- **`ovf_clr`:** if `ovf_clr` and a new drop occur in the same cycle, the set wins.

## Timing
- **Reset values:** `src_valid`, `src_sop`, `src_eop` and `src_error` are 0, `src_real` and `src_imag` are 0, `ovf_sticky`=0, `busy`=0, `frame_cnt`=0. The FSM starts in IDLE, the sample count is 0 and the FIFO is empty.
- **Reset mid-frame:** flushes the FIFO and discards the partial frame. There is no eop for it.
- **Latency:** a sample accepted on edge k appears at the source after edge k. When the FIFO was empty, `src_valid` rises in the cycle following the `in_valid` cycle, so latency is 1 cycle.
- **Throughput:** one sample per clock, in and out.
- **`busy`:** registered; rises 1 cycle after `run_en` is sampled in IDLE.
- **Frame start:** the first frame begins with the first `in_valid` sampled in RUN.

## Configuration
- **`NCO_FFT_FRAMER_FRAME_CNT_EN` defined:**
  - `frame_cnt` increments once per frame, when the eop sample is counted (written or dropped).
  - It wraps from 0xFFFF to 0 and is cleared only by reset.
- **`NCO_FFT_FRAMER_FRAME_CNT_EN` undefined:** `frame_cnt` is tied to 0 and no counter logic is built.

## Test plan
- **Basic framing:** `FFT_LEN`=8, `src_ready`=1, `run_en`=1, `in_valid`=1 continuously, ramp data → beats every cycle, sop on beats 0 and 8, eop on beats 7 and 15, `src_error`=0, latency 1.
- **Back-pressure overflow:** `FIFO_DEPTH`=4, `src_ready`=0 for 10 input samples → 4 samples stored, 6 dropped, `ovf_sticky`=1. After releasing `src_ready`, the frame's eop beat carries `src_error`=1. The next frame has `src_error`=0.
- **Stop mid-frame:** deassert `run_en` after 3 of 8 samples → FSM goes to FINISH, 5 more samples accepted, eop delivered, `busy` falls after eop, and later `in_valid` is ignored.
- **Sticky clear race:** `ovf_clr` pulsed in the same cycle as a drop → `ovf_sticky` stays 1. A clear with no drop → 0.
- **Async reset mid-frame:** assert `reset_n`=0 asynchronously with 3 words in the FIFO → all outputs take their reset values immediately. After release, the next frame starts with sop.
- **Frame counter:** with the macro defined, 3 complete frames → `frame_cnt`=3. With it undefined → `frame_cnt`=0.

Source files
------------

// File: rtl/nco_fft_framer.sv
// Packs the NCO sine/cosine stream into fixed-length complex frames on an Avalon-ST source.
// Optional completed-frame counter is built only when NCO_FFT_FRAMER_FRAME_CNT_EN is defined.
module nco_fft_framer #(
  parameter int MPR        = 14,
  parameter int FFT_LEN    = 1024,
  parameter int LOG2_LEN   = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int LOG2_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run_en,
  input  logic              in_valid,
  input  logic [MPR-1:0]    in_sin,
  input  logic [MPR-1:0]    in_cos,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [MPR-1:0]    src_real,
  output logic [MPR-1:0]    src_imag,
  output logic              src_error,
  output logic              ovf_sticky,
  input  logic              ovf_clr,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int WORD_W = 2*MPR + 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [LOG2_LEN-1:0]   cnt_q, cnt_d;
  logic                  frame_err_q, frame_err_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   fill_q, fill_d;
  logic [WORD_W-1:0]     mem_q [FIFO_DEPTH];

  logic              active;
  logic              sample;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic              drop;
  logic              is_sop;
  logic              is_eop;
  logic              eop_seen;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] head;

  // Fullness is judged on the registered fill level, so a same-cycle read cannot rescue a write.
  assign active   = (state_q != IDLE);
  assign sample   = in_valid & active;
  assign full     = (fill_q == (LOG2_DEPTH+1)'(FIFO_DEPTH));
  assign empty    = (fill_q == '0);
  assign wr_en    = sample & ~full;
  assign drop     = sample & full;
  assign rd_en    = ~empty & src_ready;
  assign is_sop   = (cnt_q == '0);
  assign is_eop   = (cnt_q == LOG2_LEN'(FFT_LEN - 1));
  assign eop_seen = sample & is_eop;
  assign wr_word  = {is_eop & frame_err_q, is_eop, is_sop, in_cos, in_sin};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = frame_err_q;
    ovf_d       = ovf_q;

    if (sample) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (eop_seen) begin
      frame_err_d = 1'b0;
    end else if (drop) begin
      frame_err_d = 1'b1;
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    // Stopping uses the post-sample count so a frame that just completed returns straight to IDLE.
    case (state_q)
      IDLE: begin
        if (run_en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!run_en) begin
          state_d = (cnt_d == '0) ? IDLE : FINISH;
        end
      end
      FINISH: begin
        if (eop_seen) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
    end
  end

  // Storage needs no reset: the pointers flush it and the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign src_valid  = ~empty;
  assign src_error  = ~empty & head[2*MPR+2];
  assign src_eop    = ~empty & head[2*MPR+1];
  assign src_sop    = ~empty & head[2*MPR];
  assign src_real   = empty ? '0 : head[2*MPR-1:MPR];
  assign src_imag   = empty ? '0 : head[MPR-1:0];
  assign ovf_sticky = ovf_q;
  assign busy       = busy_q;

`ifdef NCO_FFT_FRAMER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (eop_seen) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
